axis_packet_fifo: RTL

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/axis_packet_fifo.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_packet_fifo.sv
// ---------------------------------------------------------------------------
// axis_packet_fifo
//
// AXI4-Stream packet FIFO with a first-word-fall-through egress.
//   STORE_FWD=1 : a packet becomes visible at egress only once its tlast beat
//                 has been written with good status. Errored packets (tuser on
//                 tlast, DROP_ON_ERR=1) and packets that overflow the buffer are
//                 discarded by rewinding the write pointer.
//   STORE_FWD=0 : cut-through; every written beat is visible immediately and
//                 tuser is carried through to egress on the tlast beat.
//
// Ports
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_s_axis_* / o_s_axis_*   ingress stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   o_m_axis_* / i_m_axis_*   egress stream  (tvalid/tready/tdata/tkeep/tlast/tuser)
//   o_level                   beats held (written but not yet handed out)
//   o_pkt_count               committed packets not yet fully sent
//   o_drop                    one-cycle pulse per discarded packet
// ---------------------------------------------------------------------------
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 7,
    parameter int STORE_FWD   = 1,
    parameter int DROP_ON_ERR = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_s_axis_tvalid,
    output logic                      o_s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     i_s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   i_s_axis_tkeep,
    input  logic                      i_s_axis_tlast,
    input  logic                      i_s_axis_tuser,
    output logic                      o_m_axis_tvalid,
    input  logic                      i_m_axis_tready,
    output logic [DATA_WIDTH-1:0]     o_m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   o_m_axis_tkeep,
    output logic                      o_m_axis_tlast,
    output logic                      o_m_axis_tuser,
    output logic [ADDR_WIDTH:0]       o_level,
    output logic [ADDR_WIDTH:0]       o_pkt_count,
    output logic                      o_drop
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

    typedef enum logic {
        ST_PASS    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_in_en;
    logic [ADDR_WIDTH:0]    r_wr;
    logic [ADDR_WIDTH:0]    r_commit;
    logic [ADDR_WIDTH:0]    r_fetch;
    logic [ADDR_WIDTH:0]    r_rd;
    logic [ADDR_WIDTH:0]    r_pkt_count;
    logic                   r_drop;
    logic [WORD_WIDTH-1:0]  r_mem [DEPTH];
    logic [WORD_WIDTH-1:0]  r_ram_q;
    logic                   r_s1_valid;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [KEEP_WIDTH-1:0]  r_out_keep;
    logic                   r_out_last;
    logic                   r_out_user;

    logic [ADDR_WIDTH:0]    w_used;
    logic                   w_full;
    logic                   w_in_ready;
    logic                   w_in_hs;
    logic                   w_wr_en;
    logic                   w_rewind;
    logic                   w_commit_beat;
    logic                   w_commit_pkt;
    logic                   w_drop_now;
    logic                   w_out_hs;
    logic                   w_s1_adv;
    logic                   w_fetch;

    // r_rd retires a slot only on the egress handshake, so the beats sitting
    // in the read pipeline still count as held and (wr - rd) is the level.
    assign w_used     = r_wr - r_rd;
    assign w_full     = (w_used == FULL_LEVEL);
    // Store-and-forward never back-pressures: overflow is handled by DISCARD.
    assign w_in_ready = (STORE_FWD != 0) ? r_in_en : (r_in_en & ~w_full);
    assign w_in_hs    = i_s_axis_tvalid & w_in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_PASS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (STORE_FWD != 0) begin
            case (r_state)
                ST_PASS:    if (w_in_hs && w_full && !i_s_axis_tlast) w_state_next = ST_DISCARD;
                ST_DISCARD: if (w_in_hs && i_s_axis_tlast)            w_state_next = ST_PASS;
                default:    w_state_next = ST_PASS;
            endcase
        end
    end

    // ---------------- FSM: outputs (ingress control) ----------------
    always_comb begin
        w_wr_en       = 1'b0;
        w_rewind      = 1'b0;
        w_commit_beat = 1'b0;
        w_commit_pkt  = 1'b0;
        w_drop_now    = 1'b0;
        if (STORE_FWD != 0) begin
            case (r_state)
                ST_PASS: begin
                    if (w_in_hs) begin
                        if (w_full) begin
                            // No room: a tlast here ends the packet immediately.
                            if (i_s_axis_tlast) begin
                                w_rewind   = 1'b1;
                                w_drop_now = 1'b1;
                            end
                        end else begin
                            w_wr_en = 1'b1;
                            if (i_s_axis_tlast) begin
                                if ((DROP_ON_ERR != 0) && i_s_axis_tuser) begin
                                    w_rewind   = 1'b1;
                                    w_drop_now = 1'b1;
                                end else begin
                                    w_commit_beat = 1'b1;
                                    w_commit_pkt  = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DISCARD: begin
                    if (w_in_hs && i_s_axis_tlast) begin
                        w_rewind   = 1'b1;
                        w_drop_now = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            w_wr_en       = w_in_hs;
            w_commit_beat = w_in_hs;
            w_commit_pkt  = w_in_hs & i_s_axis_tlast;
        end
    end

    // ---------------- Egress pipeline: RAM read stage -> output register ----
    assign w_out_hs = r_out_valid & i_m_axis_tready;
    assign w_s1_adv = r_s1_valid & (~r_out_valid | i_m_axis_tready);
    assign w_fetch  = (r_fetch != r_commit) & (~r_s1_valid | w_s1_adv);

    // Block RAM with registered read. A fetched slot can never alias the write
    // slot: that would need wr - rd == DEPTH, in which case no write happens.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr[ADDR_WIDTH-1:0]] <= {i_s_axis_tuser, i_s_axis_tlast, i_s_axis_tkeep, i_s_axis_tdata};
        end
        if (w_fetch) begin
            r_ram_q <= r_mem[r_fetch[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_en     <= 1'b0;
            r_wr        <= '0;
            r_commit    <= '0;
            r_fetch     <= '0;
            r_rd        <= '0;
            r_pkt_count <= '0;
            r_drop      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
            r_drop  <= w_drop_now;

            if (w_rewind) begin
                r_wr <= r_commit;
            end else if (w_wr_en) begin
                r_wr <= r_wr + PTR_ONE;
            end
            if (w_commit_beat) begin
                r_commit <= r_wr + PTR_ONE;
            end
            if (w_fetch) begin
                r_fetch <= r_fetch + PTR_ONE;
            end
            if (w_out_hs) begin
                r_rd <= r_rd + PTR_ONE;
            end

            case ({w_commit_pkt, w_out_hs & r_out_last})
                2'b10:   r_pkt_count <= r_pkt_count + PTR_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - PTR_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase

            r_s1_valid <= w_fetch | (r_s1_valid & ~w_s1_adv);

            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_ram_q[DATA_WIDTH-1:0];
                r_out_keep  <= r_ram_q[DATA_WIDTH +: KEEP_WIDTH];
                r_out_last  <= r_ram_q[DATA_WIDTH + KEEP_WIDTH];
                // Error flag is only forwarded in cut-through mode.
                r_out_user  <= (STORE_FWD == 0) & r_ram_q[DATA_WIDTH + KEEP_WIDTH + 1];
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_s_axis_tready = w_in_ready;
    assign o_m_axis_tvalid = r_out_valid;
    assign o_m_axis_tdata  = r_out_data;
    assign o_m_axis_tkeep  = r_out_keep;
    assign o_m_axis_tlast  = r_out_last;
    assign o_m_axis_tuser  = r_out_user;
    assign o_level         = w_used;
    assign o_pkt_count     = r_pkt_count;
    assign o_drop          = r_drop;

endmodule
